// File: rtl/aes_block_packer.sv
// -----------------------------------------------------------------------------
// aes_block_packer
//
// Upstream feeder for a pipelined AES cipher core. It collects an 8-bit byte
// stream (valid/ready) into 128-bit blocks laid out as the core expects
// (byte k at bits [8k +: 8]). When PAD_EN is set, the final block of a message
// gets PKCS#7 padding. When PAD_EN is clear, the final block is zero-filled
// instead. The core itself has no valid or stall, so a LAT-deep tag delay line
// follows each block through the core and tells the consumer when the core's
// output holds a ciphertext.
//
// Parameters
//   NR      cipher rounds (10/12/14); only used to derive LAT
//   LAT     cycles from a block on the core input to its ciphertext
//   PAD_EN  1: PKCS#7 padding, 0: zero-fill the partial final block
//
// Ports
//   clk       clock, all flops on posedge
//   rst_n     asynchronous active-low reset
//   s_data    input byte
//   s_valid   s_data valid
//   s_last    s_data is the last byte of the message
//   s_ready   byte accepted on posedge when s_valid && s_ready
//   blk       packed block for the core input
//   blk_vld   one-cycle strobe: blk holds a new block
//   blk_last  qualified by blk_vld: final block of the message
//   ct_vld    blk_vld delayed LAT cycles (aligned with the core output)
//   ct_last   blk_last delayed LAT cycles
// -----------------------------------------------------------------------------
module aes_block_packer #(
    parameter int NR     = 10,
    parameter int LAT    = NR + 1,
    parameter bit PAD_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   s_data,
    input  logic         s_valid,
    input  logic         s_last,
    output logic         s_ready,
    output logic [127:0] blk,
    output logic         blk_vld,
    output logic         blk_last,
    output logic         ct_vld,
    output logic         ct_last
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        XTRA = 2'd2,
        EMIT = 2'd3
    } state_t;

    state_t         state_r, state_s;
    logic [3:0]     idx_r, idx_s;
    logic [3:0]     pad_n_r, pad_n_s;
    logic           last_r, last_s;
    logic           xtra_pend_r, xtra_pend_s;
    logic [127:0]   blk_r, blk_s;
    logic           blk_vld_r, blk_vld_s;
    logic           blk_last_r, blk_last_s;
    logic [1:0]     dl_r [LAT];
    logic           accept_s;

    assign accept_s = s_valid && (state_r == FILL);

    // Next-state, block contents and emit strobes
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        pad_n_s     = pad_n_r;
        last_s      = last_r;
        xtra_pend_s = xtra_pend_r;
        blk_s       = blk_r;
        blk_vld_s   = 1'b0;
        blk_last_s  = 1'b0;
        case (state_r)
            FILL: begin
                if (accept_s) begin
                    blk_s[{idx_r, 3'b000} +: 8] = s_data;
                    if (idx_r != 4'd15) begin
                        if (s_last) begin
                            // Remaining slots after this byte become padding
                            pad_n_s = 4'd15 - idx_r;
                            state_s = PAD;
                        end else begin
                            idx_s = idx_r + 4'd1;
                        end
                    end else begin
                        idx_s = 4'd0;
                        if (s_last && PAD_EN) begin
                            // Full final block still needs a whole pad block
                            state_s = XTRA;
                        end else begin
                            state_s    = EMIT;
                            last_s     = s_last;
                            blk_vld_s  = 1'b1;
                            blk_last_s = s_last;
                        end
                    end
                end else begin
                    state_s = FILL;
                end
            end
            PAD: begin
                for (int k = 0; k < 16; k++) begin
                    if (idx_r < 4'(k)) begin
                        blk_s[8*k +: 8] = PAD_EN ? {4'h0, pad_n_r} : 8'h00;
                    end else begin
                        blk_s[8*k +: 8] = blk_r[8*k +: 8];
                    end
                end
                idx_s      = 4'd0;
                last_s     = 1'b1;
                state_s    = EMIT;
                blk_vld_s  = 1'b1;
                blk_last_s = 1'b1;
            end
            XTRA: begin
                // First visit emits the data block; the visit after that
                // emit loads the all-16 pad block
                if (xtra_pend_r) begin
                    blk_s       = {16{8'h10}};
                    xtra_pend_s = 1'b0;
                    last_s      = 1'b1;
                    blk_last_s  = 1'b1;
                end else begin
                    xtra_pend_s = 1'b1;
                    last_s      = 1'b0;
                    blk_last_s  = 1'b0;
                end
                state_s   = EMIT;
                blk_vld_s = 1'b1;
            end
            EMIT: begin
                if (xtra_pend_r) begin
                    state_s = XTRA;
                end else begin
                    state_s = FILL;
                end
            end
            default: begin
                state_s = FILL;
            end
        endcase
    end

    // Controller and block register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= FILL;
            idx_r       <= 4'd0;
            pad_n_r     <= 4'd0;
            last_r      <= 1'b0;
            xtra_pend_r <= 1'b0;
            blk_r       <= 128'd0;
            blk_vld_r   <= 1'b0;
            blk_last_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            pad_n_r     <= pad_n_s;
            last_r      <= last_s;
            xtra_pend_r <= xtra_pend_s;
            blk_r       <= blk_s;
            blk_vld_r   <= blk_vld_s;
            blk_last_r  <= blk_last_s;
        end
    end

    // Tag delay line that mirrors the core's fixed latency; shifts every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                dl_r[i] <= 2'b00;
            end
        end else begin
            dl_r[0] <= {blk_vld_r, blk_last_r};
            for (int i = 1; i < LAT; i++) begin
                dl_r[i] <= dl_r[i-1];
            end
        end
    end

    assign s_ready  = (state_r == FILL);
    assign blk      = blk_r;
    assign blk_vld  = blk_vld_r;
    assign blk_last = blk_last_r;
    assign ct_vld   = dl_r[LAT-1][1];
    assign ct_last  = dl_r[LAT-1][0];

endmodule
